// File: rtl/sdp_nrdma_bn_unpack_pkg.sv
// Shared SDP constants for the BN operand stream layout and small elaboration helpers.
package sdp_nrdma_bn_unpack_pkg;

    localparam int BN_LANES   = 32;
    localparam int BN_LANE_W  = 16;
    localparam int BN_DATA_W  = BN_LANES * BN_LANE_W;
    localparam int BN_END_BIT = BN_DATA_W;
    localparam int BN_PD_W    = BN_DATA_W + 1;
    localparam int STALL_W    = 32;

    // Ceiling log2, never below 1 so single-value counters still get a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sdp_nrdma_bn_unpack_stall_cnt.sv
// Saturating 32-bit perf counter: clear beats load beats increment; never wraps.
module sdp_nrdma_bn_unpack_stall_cnt
    import sdp_nrdma_bn_unpack_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [STALL_W-1:0] load_val_i,
    input  logic               inc_i,
    output logic [STALL_W-1:0] cnt_o
);

    localparam logic [STALL_W-1:0] CNT_MAX = {STALL_W{1'b1}};

    logic [STALL_W-1:0] cnt_q;
    logic [STALL_W-1:0] cnt_d;

    // Next-count selection with clear priority and saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sdp_nrdma_bn_unpack.sv
// Serializes wide BN operand words into OUT_LANES-wide beats and counts output stall cycles.
module sdp_nrdma_bn_unpack
    import sdp_nrdma_bn_unpack_pkg::*;
#(
    parameter int IN_LANES  = BN_LANES,
    parameter int OUT_LANES = 16,
    parameter int LANE_W    = BN_LANE_W
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    input  logic                          op_load,
    input  logic                          in_pvld,
    output logic                          in_prdy,
    input  logic [IN_LANES*LANE_W:0]      in_pd,
    output logic                          out_pvld,
    input  logic                          out_prdy,
    output logic [OUT_LANES*LANE_W:0]     out_pd,
    output logic [31:0]                   dp2reg_bn_unpack_stall
);

    localparam int IN_W  = IN_LANES * LANE_W;
    localparam int OUT_W = OUT_LANES * LANE_W;
    localparam int RATIO = IN_LANES / OUT_LANES;
    localparam int CNT_W = clog2_min1(RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    logic [IN_W-1:0]  hold_q, hold_d;
    logic             hold_end_q, hold_end_d;
    logic             full_q, full_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic             last_beat_s;
    logic             out_fire_s;
    logic             in_fire_s;
    logic [OUT_W-1:0] out_data_s;

    assign last_beat_s = (beat_q == LAST_BEAT);
    assign out_fire_s  = full_q & out_prdy;
    assign in_prdy     = ~full_q | (out_fire_s & last_beat_s);
    assign in_fire_s   = in_pvld & in_prdy;

    // Holding register / beat counter next state; a load on the last beat leaves no bubble.
    always_comb begin
        hold_d     = hold_q;
        hold_end_d = hold_end_q;
        full_d     = full_q;
        beat_d     = beat_q;
        if (in_fire_s) begin
            hold_d     = in_pd[IN_W-1:0];
            hold_end_d = in_pd[IN_W];
            full_d     = 1'b1;
            beat_d     = '0;
        end else if (out_fire_s) begin
            if (last_beat_s) begin
                full_d = 1'b0;
                beat_d = '0;
            end else begin
                beat_d = beat_q + CNT_W'(1);
            end
        end else begin
            full_d = full_q;
        end
    end

    // Serializer state registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hold_q     <= '0;
            hold_end_q <= 1'b0;
            full_q     <= 1'b0;
            beat_q     <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_end_q <= hold_end_d;
            full_q     <= full_d;
            beat_q     <= beat_d;
        end
    end

    // Beat slice mux, driven from the holding register even when idle.
    always_comb begin
        out_data_s = hold_q[OUT_W-1:0];
        for (int r = 0; r < RATIO; r++) begin
            if (beat_q == CNT_W'(r)) begin
                out_data_s = hold_q[r*OUT_W +: OUT_W];
            end else begin
                out_data_s = out_data_s;
            end
        end
    end

    assign out_pvld = full_q;
    assign out_pd   = {hold_end_q & last_beat_s, out_data_s};

    sdp_nrdma_bn_unpack_stall_cnt u_stall_cnt (
        .clk_i      (nvdla_core_clk),
        .rst_n_i    (nvdla_core_rstn),
        .clr_i      (op_load),
        .load_i     (1'b0),
        .load_val_i ({STALL_W{1'b0}}),
        .inc_i      (full_q & ~out_prdy),
        .cnt_o      (dp2reg_bn_unpack_stall)
    );

endmodule

// File: tb/tb_sdp_nrdma_bn_unpack.sv
// Scoreboard bench for the BN unpacker: directed scenarios plus random handshakes.
module tb_sdp_nrdma_bn_unpack;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_load;
    logic         in_pvld;
    logic         in_prdy;
    logic [512:0] in_pd;
    logic         out_pvld;
    logic         out_prdy;
    logic [256:0] out_pd;
    logic [31:0]  stall;

    logic         sc_clr, sc_load, sc_inc;
    logic [31:0]  sc_val, sc_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [256:0] sb_q[$];
    logic         s_in_prdy, s_out_pvld, s_in_fire, s_out_fire;
    logic [256:0] s_out_pd;
    logic [31:0]  s_stall;

    always #5 clk = ~clk;

    sdp_nrdma_bn_unpack dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rstn        (rst_n),
        .op_load                (op_load),
        .in_pvld                (in_pvld),
        .in_prdy                (in_prdy),
        .in_pd                  (in_pd),
        .out_pvld               (out_pvld),
        .out_prdy               (out_prdy),
        .out_pd                 (out_pd),
        .dp2reg_bn_unpack_stall (stall)
    );

    sdp_nrdma_bn_unpack_stall_cnt u_sat (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (sc_clr),
        .load_i     (sc_load),
        .load_val_i (sc_val),
        .inc_i      (sc_inc),
        .cnt_o      (sc_cnt)
    );

    task automatic chk(input string tag, input logic [512:0] obs, input logic [512:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [512:0] mk_word(input logic [15:0] base, input logic e);
        logic [512:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w[i*16 +: 16] = base + 16'(i);
        w[512] = e;
        return w;
    endfunction

    // One clock: drive at negedge, sample 1ns before posedge, update scoreboard.
    task automatic step(input logic v, input logic [512:0] pd, input logic ordy, input logic ld);
        logic [256:0] exp;
        @(negedge clk);
        in_pvld  = v;
        in_pd    = pd;
        out_prdy = ordy;
        op_load  = ld;
        #4;
        s_in_prdy  = in_prdy;
        s_out_pvld = out_pvld;
        s_out_pd   = out_pd;
        s_stall    = stall;
        s_in_fire  = in_pvld & in_prdy;
        s_out_fire = out_pvld & out_prdy;
        if (s_in_fire) begin
            sb_q.push_back({1'b0, pd[255:0]});
            sb_q.push_back({pd[512], pd[511:256]});
        end
        if (s_out_fire) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 513'd1, 513'd0);
            end else begin
                exp = sb_q.pop_front();
                chk("sb_beat", {256'd0, s_out_pd}, {256'd0, exp});
            end
        end
    endtask

    initial begin
        logic [512:0] w1, w3, w4, w5, w6, pend_word;
        logic [512:0] zero_w;
        logic         pend_vld;
        int           k, beats, bubbles, last_rdy, sent, cyc;

        zero_w   = '0;
        rst_n    = 1'b0;
        op_load  = 1'b0;
        in_pvld  = 1'b0;
        in_pd    = '0;
        out_prdy = 1'b0;
        sc_clr   = 1'b0;
        sc_load  = 1'b0;
        sc_inc   = 1'b0;
        sc_val   = '0;
        #3;
        chk("rst_out_pvld", {512'd0, out_pvld}, 513'd0);
        chk("rst_out_pd",   {256'd0, out_pd}, 513'd0);
        chk("rst_in_prdy",  {512'd0, in_prdy}, 513'd1);
        chk("rst_stall",    {481'd0, stall}, 513'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single word, both beats, layer_end on the last beat only.
        w1 = mk_word(16'h0100, 1'b1);
        step(1'b1, w1, 1'b1, 1'b0);
        chk("t1_accept", {512'd0, s_in_fire}, 513'd1);
        step(1'b0, zero_w, 1'b1, 1'b0);
        chk("t1_b0_vld", {512'd0, s_out_pvld}, 513'd1);
        chk("t1_b0_pd",  {256'd0, s_out_pd}, {256'd0, 1'b0, w1[255:0]});
        chk("t1_b0_rdy", {512'd0, s_in_prdy}, 513'd0);
        step(1'b0, zero_w, 1'b1, 1'b0);
        chk("t1_b1_pd",  {256'd0, s_out_pd}, {256'd0, 1'b1, w1[511:256]});
        chk("t1_b1_rdy", {512'd0, s_in_prdy}, 513'd1);
        step(1'b0, zero_w, 1'b1, 1'b0);
        chk("t1_idle", {512'd0, s_out_pvld}, 513'd0);

        // Back-to-back streaming of 8 words.
        k = 0; beats = 0; bubbles = 0; last_rdy = 0;
        for (int c = 0; c < 40 && beats < 16; c++) begin
            step(k < 8, mk_word(16'(k * 32), k == 7), 1'b1, 1'b0);
            if (s_out_fire) begin
                beats++;
                if ((beats % 2 == 0) && s_in_prdy) last_rdy++;
            end else if (beats > 0) begin
                bubbles++;
            end else begin
                bubbles = bubbles;
            end
            if (s_in_fire) k++;
        end
        chk("t2_beats",    513'(beats), 513'd16);
        chk("t2_bubbles",  513'(bubbles), 513'd0);
        chk("t2_last_rdy", 513'(last_rdy), 513'd8);

        // Backpressure mid-word.
        step(1'b0, zero_w, 1'b1, 1'b1);
        w3 = mk_word(16'h3000, 1'b1);
        step(1'b1, w3, 1'b1, 1'b0);
        step(1'b0, zero_w, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, zero_w, 1'b0, 1'b0);
            chk("t3_hold_pd",  {256'd0, s_out_pd}, {256'd0, 1'b1, w3[511:256]});
            chk("t3_hold_rdy", {512'd0, s_in_prdy}, 513'd0);
        end
        step(1'b0, zero_w, 1'b1, 1'b0);
        chk("t3_stall5",  {481'd0, s_stall}, 513'd5);
        chk("t3_release", {512'd0, s_out_fire}, 513'd1);

        // op_load coincident with a stall cycle.
        w4 = mk_word(16'h4000, 1'b0);
        step(1'b1, w4, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, zero_w, 1'b0, 1'b0);
        step(1'b0, zero_w, 1'b0, 1'b1);
        chk("t4_stall3", {481'd0, s_stall}, 513'd3);
        step(1'b0, zero_w, 1'b0, 1'b0);
        chk("t4_cleared", {481'd0, s_stall}, 513'd0);
        step(1'b0, zero_w, 1'b1, 1'b0);
        step(1'b0, zero_w, 1'b1, 1'b0);

        // Saturation on a standalone counter preloaded near the top.
        @(negedge clk);
        sc_load = 1'b1; sc_val = 32'hFFFF_FFFE;
        @(negedge clk);
        sc_load = 1'b0; sc_inc = 1'b1;
        #1 chk("sat_pre", {481'd0, sc_cnt}, {481'd0, 32'hFFFF_FFFE});
        @(negedge clk);
        #1 chk("sat_top", {481'd0, sc_cnt}, {481'd0, 32'hFFFF_FFFF});
        @(negedge clk);
        @(negedge clk);
        #1 chk("sat_hold", {481'd0, sc_cnt}, {481'd0, 32'hFFFF_FFFF});
        sc_clr = 1'b1;
        @(negedge clk);
        #1 chk("sat_clr", {481'd0, sc_cnt}, 513'd0);
        sc_clr = 1'b0; sc_inc = 1'b0;

        // Reset after beat 0 of a word: word discarded, block restarts empty.
        w5 = mk_word(16'h5000, 1'b1);
        step(1'b1, w5, 1'b1, 1'b0);
        step(1'b0, zero_w, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", {512'd0, out_pvld}, 513'd0);
        chk("t5_rst_pd",  {256'd0, out_pd}, 513'd0);
        sb_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        w6 = mk_word(16'h6000, 1'b0);
        step(1'b1, w6, 1'b1, 1'b0);
        chk("t5_in_prdy", {512'd0, s_in_prdy}, 513'd1);
        step(1'b0, zero_w, 1'b1, 1'b0);
        chk("t5_first_beat", {256'd0, s_out_pd}, {256'd0, 1'b0, w6[255:0]});
        step(1'b0, zero_w, 1'b1, 1'b0);

        // Random valid/ready on both sides.
        sent = 0; cyc = 0; pend_vld = 1'b0; pend_word = '0;
        while ((sent < 10000) && (cyc < 80000)) begin
            if (!pend_vld && ($urandom_range(0, 3) != 0)) begin
                for (int i = 0; i < 16; i++) pend_word[i*32 +: 32] = $urandom;
                pend_word[512] = ($urandom_range(0, 3) == 0);
                pend_vld = 1'b1;
            end
            step(pend_vld, pend_word, $urandom_range(0, 3) != 0, 1'b0);
            if (s_in_fire) begin
                pend_vld = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("rand_timeout", 513'(sent), 513'd10000);
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) step(1'b0, zero_w, 1'b1, 1'b0);
        chk("sb_leftover", 513'(sb_q.size()), 513'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
